// File: rtl/truth_table_sweep.sv
// Sweeps all 2**N_VARS input rows and streams N_CH truth-table outputs per beat, counting minterms.
// Optional macro TTS_EQUIV_EN adds a first-difference check of channel 0 against the other channels.
module truth_table_sweep #(
   parameter int unsigned N_VARS = 3,
   parameter int unsigned N_CH   = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         hold,
   input  logic [N_CH*(2**N_VARS)-1:0]  tt_in,
   output logic                         busy,
   output logic                         valid,
   output logic [N_VARS-1:0]            idx,
   output logic [N_CH-1:0]              f_out,
   output logic                         done,
   output logic [N_CH*(N_VARS+1)-1:0]   ones_cnt,
   output logic                         mismatch,
   output logic [N_VARS-1:0]            mm_idx
);

   localparam int unsigned ROWS = 2**N_VARS;
   localparam int unsigned CW   = N_VARS + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SWEEP = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [1:0]           state_q, state_d;
   logic [N_CH*ROWS-1:0] snap_q;
   logic [N_VARS-1:0]    idx_q;
   logic [N_CH-1:0]      f_cur;
   logic [N_CH-1:0]      f_last_q;
   logic [CW-1:0]        ones_q [N_CH];
   logic [ROWS-1:0]      tab [N_CH];
   logic                 beat;

   // A beat is any SWEEP cycle not stalled by hold; hold acts in the same cycle.
   assign beat = (state_q == ST_SWEEP) && !hold;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign tab[g]                = snap_q[g*ROWS +: ROWS];
      assign f_cur[g]              = tab[g][idx_q];
      assign ones_cnt[g*CW +: CW]  = ones_q[g];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (start) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_SWEEP;
         ST_SWEEP: if (beat && (&idx_q)) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         snap_q   <= '0;
         idx_q    <= '0;
         f_last_q <= '0;
         for (int c = 0; c < N_CH; c++) ones_q[c] <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_LOAD) begin
            snap_q <= tt_in;
            idx_q  <= '0;
            for (int c = 0; c < N_CH; c++) ones_q[c] <= '0;
         end else if (beat) begin
            // Wraps to 0 on the last row.
            idx_q    <= idx_q + 1'b1;
            f_last_q <= f_cur;
            for (int c = 0; c < N_CH; c++) ones_q[c] <= ones_q[c] + CW'(f_cur[c]);
         end
      end
   end

   assign busy  = (state_q != ST_IDLE);
   assign valid = beat;
   assign idx   = idx_q;
   assign f_out = beat ? f_cur : f_last_q;
   assign done  = (state_q == ST_DONE);

`ifdef TTS_EQUIV_EN
   logic              mm_q;
   logic [N_VARS-1:0] mm_idx_q;
   logic              diff;

   always_comb begin
      diff = 1'b0;
      for (int c = 1; c < N_CH; c++) diff = diff | (f_cur[c] ^ f_cur[0]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mm_q     <= 1'b0;
         mm_idx_q <= '0;
      end else if (state_q == ST_LOAD) begin
         mm_q     <= 1'b0;
         mm_idx_q <= '0;
      end else if (beat && diff && !mm_q) begin
         mm_q     <= 1'b1;
         mm_idx_q <= idx_q;
      end
   end

   assign mismatch = mm_q;
   assign mm_idx   = mm_idx_q;
`else
   assign mismatch = 1'b0;
   assign mm_idx   = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweep.sv
// Randomized self-checking bench for truth_table_sweep against a table-driven reference model.
module tb_truth_table_sweep;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        hold = 1'b0;
   logic [15:0] tt_in = '0;
   logic        busy, valid, done, mismatch;
   logic [2:0]  idx, mm_idx;
   logic [1:0]  f_out;
   logic [7:0]  ones_cnt;

   logic        w_start = 1'b0;
   logic        w_hold = 1'b0;
   logic [47:0] w_tt = '0;
   logic        w_busy, w_valid, w_done, w_mm;
   logic [3:0]  w_idx, w_mm_idx;
   logic [2:0]  w_f;
   logic [14:0] w_ones;

   int          n_vec = 0;
   int          n_err = 0;
   logic [1:0]  last_f = '0;

   truth_table_sweep #(.N_VARS(3), .N_CH(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .hold(hold), .tt_in(tt_in),
      .busy(busy), .valid(valid), .idx(idx), .f_out(f_out), .done(done),
      .ones_cnt(ones_cnt), .mismatch(mismatch), .mm_idx(mm_idx)
   );

   truth_table_sweep #(.N_VARS(4), .N_CH(3)) u_wide (
      .clk(clk), .rst_n(rst_n), .start(w_start), .hold(w_hold), .tt_in(w_tt),
      .busy(w_busy), .valid(w_valid), .idx(w_idx), .f_out(w_f), .done(w_done),
      .ones_cnt(w_ones), .mismatch(w_mm), .mm_idx(w_mm_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // mode 0: no hold, 1: hold 3 cycles at idx 4, 2: random hold. mess: tt_in=0 + start mid-sweep.
   task automatic do_sweep(input logic [15:0] tt, input int mode, input bit mess);
      logic [7:0] t0, t1;
      logic [1:0] f_exp;
      logic       exp_mm;
      logic [2:0] exp_mmi;
      int         cyc, beats, held, cnt0, cnt1;
      t0 = tt[7:0];
      t1 = tt[15:8];
      exp_mm = 1'b0;
      exp_mmi = '0;
`ifdef TTS_EQUIV_EN
      for (int i = 0; i < 8; i++) begin
         if (!exp_mm && (t0[i] != t1[i])) begin
            exp_mm = 1'b1;
            exp_mmi = 3'(i);
         end
      end
`endif
      cnt0 = 0; cnt1 = 0; beats = 0; held = 0;
      @(posedge clk); #1;
      tt_in = tt; start = 1'b1; hold = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("load_busy", busy, 1);
      check("load_valid", valid, 0);
      cyc = 1;
      while (beats < 8 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (mess) begin
            tt_in = '0;
            start = (cyc == 4);
         end
         if (mode == 1) hold = (beats == 4 && held < 3);
         else if (mode == 2) hold = ($urandom_range(0, 3) == 0);
         else hold = 1'b0;
         @(negedge clk);
         if (hold) begin
            held++;
            check("hold_valid", valid, 0);
            check("hold_idx", idx, beats);
            check("hold_f", f_out, last_f);
         end else begin
            f_exp = {t1[beats], t0[beats]};
            check("beat_valid", valid, 1);
            check("beat_idx", idx, beats);
            check("beat_f", f_out, f_exp);
            check("run_cnt", ones_cnt, {4'(cnt1), 4'(cnt0)});
            if (held == 0) check("beat_cyc", cyc, beats + 2);
            cnt0 += int'(f_exp[0]);
            cnt1 += int'(f_exp[1]);
            last_f = f_exp;
            beats++;
         end
      end
      if (beats < 8) check("sweep_timeout", beats, 8);
      @(posedge clk); #1;
      hold = 1'b0; start = 1'b0;
      @(negedge clk);
      cyc++;
      check("done_pulse", done, 1);
      check("done_valid", valid, 0);
      check("done_busy", busy, 1);
      if (held == 0) check("done_cyc", cyc, 10);
      check("done_cnt", ones_cnt, {4'($countones(t1)), 4'($countones(t0))});
      check("done_idx", idx, 0);
      check("done_f", f_out, last_f);
      check("done_mm", mismatch, exp_mm);
      check("done_mm_idx", mm_idx, exp_mmi);
      @(posedge clk); #1;
      @(negedge clk);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_cnt", ones_cnt, {4'($countones(t1)), 4'($countones(t0))});
      check("idle_mm", mismatch, exp_mm);
   endtask

   task automatic reset_mid_sweep();
      @(posedge clk); #1;
      tt_in = 16'hF0F3; start = 1'b1; hold = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("pre_rst_idx", idx, 5);
      #1 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_idx", idx, 0);
      check("rst_f", f_out, 0);
      check("rst_cnt", ones_cnt, 0);
      last_f = '0;
      @(posedge clk);
      @(negedge clk);
      check("rst_no_done", done, 0);
      rst_n = 1'b1;
   endtask

   task automatic wide_sweep();
      int cyc, beats, done_cyc;
      @(posedge clk); #1;
      w_tt = '1; w_start = 1'b1;
      @(posedge clk); #1;
      w_start = 1'b0;
      cyc = 1; beats = 0; done_cyc = 0;
      while (done_cyc == 0 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         @(negedge clk);
         if (w_valid) begin
            check("w_idx", w_idx, beats);
            check("w_f", w_f, 3'b111);
            beats++;
         end
         if (w_done) done_cyc = cyc;
      end
      check("w_beats", beats, 16);
      check("w_done_cyc", done_cyc, 18);
      check("w_ones", w_ones, {5'd16, 5'd16, 5'd16});
      check("w_mm", w_mm, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      tt_in = 16'($urandom);
      start = 1'($urandom);
      hold = 1'($urandom);
      w_tt = {16'($urandom), 32'($urandom)};
      w_start = 1'($urandom);
      #3;
      check("reset_busy", busy, 0);
      check("reset_valid", valid, 0);
      check("reset_done", done, 0);
      check("reset_idx", idx, 0);
      check("reset_f", f_out, 0);
      check("reset_cnt", ones_cnt, 0);
      check("reset_mm", mismatch, 0);
      check("reset_mm_idx", mm_idx, 0);
      check("reset_w_busy", w_busy, 0);
      check("reset_w_ones", w_ones, 0);
      start = 1'b0; hold = 1'b0; w_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      do_sweep(16'hF0F3, 0, 1'b0);
      do_sweep(16'hF0F3, 1, 1'b0);
      do_sweep(16'hF0F3, 1, 1'b1);
      do_sweep(16'hF3F3, 0, 1'b0);
      reset_mid_sweep();
      do_sweep(16'hF0F3, 0, 1'b0);
      repeat (8) do_sweep(16'($urandom), 2, 1'($urandom_range(0, 1)));
      do_sweep(16'h0000, 2, 1'b0);
      do_sweep(16'hFFFF, 0, 1'b0);
      wide_sweep();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
